asyncio_store_unit: RTL and testbench
=====================================

Name: asyncio_store_unit

Overview:
- Downstream stage of the asyncio reader.
- Accepts its store requests (word, byte address, remaining length) and buffers them in a small FIFO.
- Commits them to the core's data memory write port in cycles where the CPU does not own memory.
- Flags completion when the last word of an array transfer, with length 1 at accept, has been written.

Parameters:
- ADDRESS_WIDTH, 32, byte address width of requests.
- LENGTH_WIDTH, 24, remaining-length field width.
- MEM_ADDR_WIDTH, 16, word address width of data memory.
- FIFO_DEPTH, 2, buffered requests; power of two, minimum 2.
- STARVE_LIMIT, 8, consecutive blocked cycles before forced write; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- memory_op_enable  in  1  store request valid, from reader.
- word_to_store  in  32  data to store.
- address_out  in  ADDRESS_WIDTH  byte address of this word.
- length_out  in  LENGTH_WIDTH  words remaining including this one.
- memory_op_ready  out  1  request accepted this cycle if enable is high.
- cpu_mem_busy  in  1  CPU uses the data memory port this cycle.
- cpu_stall  out  1  request that the CPU hold off memory (optional feature).
- mem_we  out  1  data memory write enable.
- mem_addr  out  MEM_ADDR_WIDTH  word address.
- mem_wdata  out  32  write data.
- transfer_done  out  1  one-cycle completion pulse.
- err_misaligned  out  1  sticky misaligned-address flag.
- busy  out  1  high while the state is not IDLE.

Behaviour:
- Reset (rst high at a rising edge), all outputs 0:
  - FIFO emptied; state IDLE.
  - Reset mid-transfer discards buffered words; no write occurs in the reset cycle.
- Accept:
  - memory_op_ready = registered "FIFO not full"; it does not look ahead to a same-cycle pop.
  - Push on memory_op_enable && memory_op_ready. Entry holds {word, address[MEM_ADDR_WIDTH+1:2], last = (length_out == 1)}.
  - Enable with ready low: no push; the reader must hold its request.
  - length_out == 0 with enable: push and write normally, last = 0; no done pulse.
- Misalignment: address_out[1:0] != 0 on a push sets err_misaligned. The flag clears only on reset. The word is still written at the truncated address.
- Write:
  - Pop the head on the edge when FIFO is not empty and cpu_mem_busy is low.
  - On that edge mem_we <= 1, and mem_addr/mem_wdata <= head fields.
  - Otherwise mem_we <= 0; mem_addr/mem_wdata hold their last values.
  - Latency: request accepted at edge N, mem_we high during cycle N+1 if CPU not busy. Minimum one cycle; unbounded while cpu_mem_busy stays high.
  - Simultaneous push and pop: both happen; occupancy is unchanged.
  - Writes occur strictly in acceptance order.
- State machine:
  - IDLE -> ACTIVE on the first push.
  - ACTIVE -> FLUSH on a push with last = 1.
  - FLUSH -> DONE when an entry with last = 1 is popped.
  - DONE -> IDLE after one cycle; transfer_done = 1 in DONE only.
  - Pushes in FLUSH are accepted and written, but do not re-arm completion until DONE passes.
- Address wrap: the word address is taken modulo 2^MEM_ADDR_WIDTH, with no error.

Optional Feature:
- Macro: ASYNCIO_STORE_STALL_EN.
- Enabled:
  - A counter increments each cycle the FIFO is non-empty and cpu_mem_busy is high, and resets on any pop.
  - When the counter reaches STARVE_LIMIT, cpu_stall <= 1. It stays high until a pop occurs, then drops the cycle after.
  - The CPU then releases the port; no other change in behaviour.
- Disabled: cpu_stall is tied to 0, no counter exists, and writes wait indefinitely.

Test Plan:
- Basic transfer: reset 30 cycles, then 3 requests (address 4, 8, 12; lengths 3, 2, 1; data 1, 2, 3) with cpu_mem_busy = 0 -> mem_we in 3 cycles at mem_addr 1, 2, 3 with data 1, 2, 3, then transfer_done exactly once, then busy = 0.
- Backpressure: cpu_mem_busy = 1, push 3 words at FIFO_DEPTH 2 -> ready low after 2 accepts and no mem_we; release busy -> 3 in-order writes, ready returns high.
- Simultaneous push/pop: one entry queued, push while popping -> occupancy stays 1, no word lost or duplicated, and the FIFO drains without a bubble.
- Misaligned address: address 6 -> err_misaligned = 1 and the write goes to mem_addr 1; err_misaligned stays 1 until rst.
- Reset mid-operation: 2 words queued with busy = 1, assert rst -> next cycle all outputs 0, and no writes after busy drops.
- Optional feature (ASYNCIO_STORE_STALL_EN): busy held at 1 with 1 entry queued -> cpu_stall rises after 8 cycles; drop busy -> write occurs and cpu_stall falls. With the macro undefined, cpu_stall stays 0 throughout.

Source files
------------

// File: rtl/asyncio_store_if.sv
// Store-request handshake between the asyncio reader (master) and the store unit (slave).
interface asyncio_store_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int LENGTH_WIDTH  = 24
);
  logic                     memory_op_enable;
  logic [31:0]              word_to_store;
  logic [ADDRESS_WIDTH-1:0] address_out;
  logic [LENGTH_WIDTH-1:0]  length_out;
  logic                     memory_op_ready;

  modport master (
    output memory_op_enable,
    output word_to_store,
    output address_out,
    output length_out,
    input  memory_op_ready
  );

  modport slave (
    input  memory_op_enable,
    input  word_to_store,
    input  address_out,
    input  length_out,
    output memory_op_ready
  );
endinterface

// File: rtl/asyncio_store_unit.sv
// Buffers reader store requests and writes them to data memory when the CPU leaves the port free.
// Optional CPU starvation stall is enabled with the macro ASYNCIO_STORE_STALL_EN.
module asyncio_store_unit #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int LENGTH_WIDTH   = 24,
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH     = 2,
  parameter int STARVE_LIMIT   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  asyncio_store_if.slave            req,
  input  logic                      cpu_mem_busy,
  output logic                      cpu_stall,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]               mem_wdata,
  output logic                      transfer_done,
  output logic                      err_misaligned,
  output logic                      busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0]               word;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic                      last;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, DONE} state_t;

  entry_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic [PTR_W:0]     count_next;
  logic               ready_r;
  logic               push;
  logic               pop;
  logic               is_last;
  entry_t             head;
  entry_t             push_entry;
  state_t             state_r;
  state_t             state_next;
  logic               done_r;
  logic               busy_r;
  logic               we_r;
  logic [MEM_ADDR_WIDTH-1:0] addr_r;
  logic [31:0]        wdata_r;
  logic               err_r;
  logic               unused_bits;

  // Upper byte-address bits are dropped on purpose: word addresses wrap silently.
  assign unused_bits = ^{req.address_out[ADDRESS_WIDTH-1:MEM_ADDR_WIDTH+2], 32'(STARVE_LIMIT)};

  assign push       = req.memory_op_enable && ready_r;
  assign pop        = (count != '0) && !cpu_mem_busy;
  assign is_last    = (req.length_out == LENGTH_WIDTH'(1));
  assign head       = fifo_mem[rd_ptr];
  assign push_entry = '{word: req.word_to_store,
                        addr: req.address_out[MEM_ADDR_WIDTH+1:2],
                        last: is_last};

  assign req.memory_op_ready = ready_r;
  assign mem_we         = we_r;
  assign mem_addr       = addr_r;
  assign mem_wdata      = wdata_r;
  assign transfer_done  = done_r;
  assign busy           = busy_r;
  assign err_misaligned = err_r;

  // Occupancy after this edge's push and pop.
  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (!push && pop) begin
      count_next = count - 1'b1;
    end else begin
      count_next = count;
    end
  end

  // FIFO storage, pointers and the registered not-full indication.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_r <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= push_entry;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count   <= count_next;
      ready_r <= (count_next != (PTR_W+1)'(FIFO_DEPTH));
    end
  end

  // Memory write port; address and data hold between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
    end else if (pop) begin
      we_r    <= 1'b1;
      addr_r  <= head.addr;
      wdata_r <= head.word;
    end else begin
      we_r <= 1'b0;
    end
  end

  // Sticky misalignment flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (push && (req.address_out[1:0] != 2'b00)) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  // Transfer state register with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next;
      done_r  <= (state_next == DONE);
      busy_r  <= (state_next != IDLE);
    end
  end

  // A single-word transfer goes straight to FLUSH; a push during DONE starts the next transfer.
  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE: begin
        if (push) begin
          state_next = is_last ? FLUSH : ACTIVE;
        end else begin
          state_next = IDLE;
        end
      end
      ACTIVE: begin
        if (push && is_last) begin
          state_next = FLUSH;
        end else begin
          state_next = ACTIVE;
        end
      end
      FLUSH: begin
        if (pop && head.last) begin
          state_next = DONE;
        end else begin
          state_next = FLUSH;
        end
      end
      DONE: begin
        if (push) begin
          state_next = is_last ? FLUSH : ACTIVE;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef ASYNCIO_STORE_STALL_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt_r;
  logic             stall_r;

  assign cpu_stall = stall_r;

  // Count cycles the head waits behind the CPU; raise the stall once the limit is reached.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r <= '0;
      stall_r      <= 1'b0;
    end else if (pop) begin
      starve_cnt_r <= '0;
      stall_r      <= 1'b0;
    end else if ((count != '0) && cpu_mem_busy) begin
      if (starve_cnt_r != CNT_W'(STARVE_LIMIT)) begin
        starve_cnt_r <= starve_cnt_r + 1'b1;
      end
      if (starve_cnt_r >= CNT_W'(STARVE_LIMIT - 1)) begin
        stall_r <= 1'b1;
      end
    end else begin
      starve_cnt_r <= starve_cnt_r;
      stall_r      <= stall_r;
    end
  end
`else
  assign cpu_stall = 1'b0;
`endif

endmodule

// File: tb/tb_asyncio_store_unit.sv
// Randomized self-checking bench for asyncio_store_unit against a queue-based reference model.
module tb_asyncio_store_unit;
  localparam int DEPTH = 2;
  localparam int LIMIT = 8;
`ifdef ASYNCIO_STORE_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_mem_busy;
  logic        cpu_stall;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        transfer_done;
  logic        err_misaligned;
  logic        busy;

  always #5 clk = ~clk;

  asyncio_store_if #(.ADDRESS_WIDTH(32), .LENGTH_WIDTH(24)) bus ();

  asyncio_store_unit #(
    .ADDRESS_WIDTH(32), .LENGTH_WIDTH(24), .MEM_ADDR_WIDTH(16),
    .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .req(bus), .cpu_mem_busy(cpu_mem_busy),
    .cpu_stall(cpu_stall), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .transfer_done(transfer_done),
    .err_misaligned(err_misaligned), .busy(busy)
  );

  typedef struct {
    logic [31:0] word;
    logic [15:0] addr;
    bit          last;
  } ent_t;

  // Reference model: pending words in acceptance order plus expected output values.
  ent_t        q[$];
  bit          m_ready, m_we, m_err, m_stall;
  logic [15:0] m_addr;
  logic [31:0] m_data;
  int          phase;   // 0 idle, 1 collecting, 2 waiting for last write, 3 done pulse
  int          starve;
  int          busy_pct;
  int          errors = 0;
  int          checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit en, input logic [31:0] w, input logic [31:0] a,
                      input logic [23:0] l, input bit b, output bit acc);
    bit   do_pop;
    bit   nonempty;
    bit   head_last;
    int   nph;
    ent_t e;
    rst                  = r;
    bus.memory_op_enable = en;
    bus.word_to_store    = w;
    bus.address_out      = a;
    bus.length_out       = l;
    cpu_mem_busy         = b;
    acc      = !r && en && m_ready;
    nonempty = (q.size() > 0);
    do_pop   = !r && nonempty && !b;
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      m_ready = 0; m_we = 0; m_addr = '0; m_data = '0; m_err = 0;
      phase = 0; starve = 0; m_stall = 0;
    end else begin
      head_last = 0;
      m_we = do_pop;
      if (do_pop) begin
        e = q.pop_front();
        m_addr = e.addr;
        m_data = e.word;
        head_last = e.last;
      end
      nph = phase;
      case (phase)
        0:       if (acc) nph = (l == 24'd1) ? 2 : 1;
        1:       if (acc && l == 24'd1) nph = 2;
        2:       if (do_pop && head_last) nph = 3;
        3:       nph = acc ? ((l == 24'd1) ? 2 : 1) : 0;
        default: nph = 0;
      endcase
      phase = nph;
      if (acc) begin
        q.push_back('{w, a[17:2], (l == 24'd1)});
        if (a[1:0] != 2'b00) m_err = 1;
      end
      m_ready = (q.size() < DEPTH);
      if (do_pop) begin
        starve = 0; m_stall = 0;
      end else if (nonempty && b) begin
        if (starve < LIMIT) starve++;
        if (starve >= LIMIT) m_stall = 1;
      end
    end
    check_eq("ready", bus.memory_op_ready, m_ready);
    check_eq("mem_we", mem_we, m_we);
    check_eq("mem_addr", mem_addr, m_addr);
    check_eq("mem_wdata", mem_wdata, m_data);
    check_eq("transfer_done", transfer_done, phase == 3);
    check_eq("busy", busy, phase != 0);
    check_eq("err_misaligned", err_misaligned, m_err);
    check_eq("cpu_stall", cpu_stall, STALL_EN ? m_stall : 1'b0);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) begin
      step(0, 0, $urandom, $urandom, 24'($urandom), ($urandom_range(99) < busy_pct), acc);
    end
  endtask

  // Reader behaviour: hold the request until accepted, within a cycle budget.
  task automatic send(input logic [31:0] w, input logic [31:0] a, input logic [23:0] l);
    bit acc;
    int n;
    n = 0;
    acc = 0;
    while (!acc && n < 200) begin
      step(0, 1, w, a, l, ($urandom_range(99) < busy_pct), acc);
      n++;
    end
    check_eq("send_accepted", acc, 1'b1);
  endtask

  initial begin
    bit          acc;
    int          len;
    logic [31:0] base;
    busy_pct = 0;
    for (int i = 0; i < 30; i++) step(1, 0, 32'd0, 32'd0, 24'd0, 1'b0, acc);

    // Basic three-word transfer.
    send(32'd1, 32'd4, 24'd3);
    send(32'd2, 32'd8, 24'd2);
    send(32'd3, 32'd12, 24'd1);
    idle(5);

    // Backpressure: two accepts fill the FIFO, third is held.
    busy_pct = 100;
    send(32'hA0, 32'h100, 24'd3);
    send(32'hA1, 32'h104, 24'd2);
    for (int i = 0; i < 3; i++) step(0, 1, 32'hA2, 32'h108, 24'd1, 1'b1, acc);
    busy_pct = 0;
    send(32'hA2, 32'h108, 24'd1);
    idle(6);

    // Starvation: one entry stuck behind a busy CPU.
    busy_pct = 100;
    send(32'hB0, 32'h200, 24'd1);
    idle(LIMIT + 3);
    busy_pct = 0;
    idle(4);

    // Push while popping.
    busy_pct = 100;
    send(32'hC0, 32'h300, 24'd2);
    busy_pct = 0;
    send(32'hC1, 32'h304, 24'd1);
    idle(4);

    // Random transfers with wrapping addresses, zero lengths and CPU contention.
    for (int t = 0; t < 40; t++) begin
      busy_pct = $urandom_range(0, 50);
      base = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(7) == 0) begin
        send($urandom, base, 24'd0);
      end else begin
        len = $urandom_range(1, 4);
        for (int k = len; k >= 1; k--) begin
          send($urandom, base + 32'((len - k) * 4), 24'(k));
          if ($urandom_range(3) == 0) idle($urandom_range(1, 2));
        end
      end
      idle($urandom_range(0, 3));
    end
    busy_pct = 0;
    idle(6);

    // Misaligned address: written at truncated word address, flag sticks.
    send(32'hD0, 32'd6, 24'd1);
    idle(4);
    send(32'hD1, 32'h40, 24'd1);
    idle(4);

    // Reset with words queued: they are discarded.
    busy_pct = 100;
    send(32'hE0, 32'h500, 24'd2);
    send(32'hE1, 32'h504, 24'd1);
    step(1, 0, 32'd0, 32'd0, 24'd0, 1'b1, acc);
    busy_pct = 0;
    idle(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
